// File: rtl/uart_peripheral.sv
// uart_peripheral: byte-wide UART behind the memory controller's register window.
// A write strobe starts a transmit frame on tx_pin. Received bytes are held in
// rx_byte and presented on uart_rddata, and uart_rx_flag shows that one is pending.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit to both directions.
// With the macro undefined, the framing is 8N1.
module uart_peripheral #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_data,
    input  logic        uart_tx_send,
    input  logic        uart_rx_clear,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic [31:0] uart_rddata,
    output logic        uart_rx_flag,
    output logic        uart_busy,
    output logic        rx_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // Fewer than four clocks per bit leaves no room for mid-bit sampling.
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_peripheral: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // Only the low byte of the bus word is transmitted.
    logic tx_data_unused;
    assign tx_data_unused = ^tx_data[31:8];

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_pin_q, tx_pin_d;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_flag_q, rx_flag_d;
    logic             rx_err_q, rx_err_d;
    logic             rx_meta_q, rx_sync_q;
`ifdef UART_PARITY_EN
    logic             rx_par_ok_q, rx_par_ok_d;
`endif

    // Transmitter state register. tx_pin is a flop so that the line is glitch-free
    // and goes back to idle-high as soon as reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_pin_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_pin_q   <= tx_pin_d;
        end
    end

    // Transmitter next state. The value of the next bit is computed one edge
    // ahead, so every bit appears on tx_pin for exactly CLKS_PER_BIT cycles.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_pin_d   = tx_pin_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_pin_d = 1'b1;
                if (uart_tx_send) begin
                    tx_byte_d  = tx_data[7:0];
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_pin_d   = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_pin_d   = tx_byte_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        tx_pin_d   = ^tx_byte_q;
`else
                        tx_state_d = TX_STOP;
                        tx_pin_d   = 1'b1;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_pin_d = tx_byte_q[tx_bit_q + 3'd1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                    tx_pin_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                tx_pin_d = 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = '0;
                tx_pin_d   = 1'b1;
            end
        endcase
    end

    // Two-flop synchronizer for the asynchronous serial input. It resets to the idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_pin;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state register, together with the held byte and the pending flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_flag_q  <= 1'b0;
            rx_err_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok_q <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_flag_q  <= rx_flag_d;
            rx_err_q   <= rx_err_d;
`ifdef UART_PARITY_EN
            rx_par_ok_q <= rx_par_ok_d;
`endif
        end
    end

    // Receiver next state. A read-clear is applied first, so that a byte that
    // completes on the same edge sets the flag again.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_flag_d  = rx_flag_q;
        rx_err_d   = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_ok_d = rx_par_ok_q;
`endif
        if (uart_rx_clear) begin
            rx_flag_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d    = '0;
                    rx_par_ok_d = ((^rx_shift_q) == rx_sync_q);
                    rx_state_d  = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
`ifdef UART_PARITY_EN
                        if (rx_par_ok_q) begin
                            rx_byte_d = rx_shift_q;
                            rx_flag_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
`else
                        rx_byte_d = rx_shift_q;
                        rx_flag_d = 1'b1;
`endif
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    assign tx_pin       = tx_pin_q;
    assign uart_busy    = (tx_state_q != TX_IDLE);
    assign uart_rddata  = {24'b0, rx_byte_q};
    assign uart_rx_flag = rx_flag_q;
    assign rx_error     = rx_err_q;

endmodule

// File: tb/tb_uart_peripheral.sv
// Self-checking bench for uart_peripheral. It uses randomized bytes and keeps its
// own reference model of the expected serial frames and the expected register state.
module tb_uart_peripheral;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 10;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Negedge index, counted from the start-bit negedge, that precedes the edge
    // on which a received frame completes. The delay is built up as follows:
    // two cycles through the synchronizer, one cycle of detection, a half-bit
    // wait, and then one full bit time per remaining frame bit.
    localparam int COMPLETE_N = 3 + CPB / 2 + CPB * (FRAME_BITS - 1) - 1;

    logic        clk;
    logic        rst;
    logic [31:0] tx_data;
    logic        uart_tx_send;
    logic        uart_rx_clear;
    logic        rx_pin;
    logic        tx_pin;
    logic [31:0] uart_rddata;
    logic        uart_rx_flag;
    logic        uart_busy;
    logic        rx_error;

    int checkCount    = 0;
    int passCount     = 0;
    int rxErrCount    = 0;
    int modelErrCount = 0;
    logic [7:0] modelByte = 8'h00;
    logic       modelFlag = 1'b0;

    uart_peripheral #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .uart_tx_send (uart_tx_send),
        .uart_rx_clear(uart_rx_clear),
        .rx_pin       (rx_pin),
        .tx_pin       (tx_pin),
        .uart_rddata  (uart_rddata),
        .uart_rx_flag (uart_rx_flag),
        .uart_busy    (uart_busy),
        .rx_error     (rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the rx_error pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst && rx_error) rxErrCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    // Line levels of one frame, in the order they are sent. Index 0 is the start bit.
    function automatic logic [10:0] frameBits(input logic [7:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic checkRxState(input string tag);
        checkOutput({tag, "_flag"}, {31'b0, uart_rx_flag}, {31'b0, modelFlag});
        checkOutput({tag, "_rddata"}, uart_rddata, {24'b0, modelByte});
        checkOutput({tag, "_errcnt"}, rxErrCount, modelErrCount);
    endtask

    task automatic applyTxStimulus(input logic [7:0] b, input bit tryResend);
        logic [10:0] bits;
        logic [23:0] junk;
        logic        expPin;
        int wrongCycles;
        int busyCycles;
        bits = frameBits(b);
        junk = 24'($urandom());
        wrongCycles = 0;
        busyCycles = 0;
        @(negedge clk);
        tx_data = {junk, b};
        uart_tx_send = 1'b1;
        for (int n = 1; n <= FRAME_BITS * CPB + 5; n++) begin
            @(negedge clk);
            expPin = (n <= FRAME_BITS * CPB) ? bits[(n - 1) / CPB] : 1'b1;
            if (tx_pin !== expPin) wrongCycles++;
            if (uart_busy) busyCycles++;
            if (n <= FRAME_BITS * CPB && (n - 1) % CPB == CPB / 2)
                checkOutput($sformatf("tx_%02h_bit%0d", b, (n - 1) / CPB), {31'b0, tx_pin}, {31'b0, expPin});
            if (tryResend && n == 37) begin
                tx_data = {junk, ~b};
                uart_tx_send = 1'b1;
            end else begin
                uart_tx_send = 1'b0;
            end
        end
        checkOutput($sformatf("tx_%02h_wrong_cycles", b), wrongCycles, 0);
        checkOutput($sformatf("tx_%02h_busy_cycles", b), busyCycles, FRAME_BITS * CPB);
    endtask

    task automatic applyRxStimulus(input logic [7:0] b, input bit badStop, input bit badParity,
                                   input int clearAt, output int flagLowCycles);
        logic [10:0] bits;
        bits = frameBits(b);
        if (badStop) bits[FRAME_BITS - 1] = 1'b0;
`ifdef UART_PARITY_EN
        if (badParity) bits[FRAME_BITS - 2] = ~bits[FRAME_BITS - 2];
`endif
        flagLowCycles = 0;
        for (int n = 0; n < FRAME_BITS * CPB; n++) begin
            @(negedge clk);
            if (!uart_rx_flag) flagLowCycles++;
            rx_pin = bits[n / CPB];
            uart_rx_clear = (n == clearAt);
        end
        @(negedge clk);
        rx_pin = 1'b1;
        uart_rx_clear = 1'b0;
        repeat (4) @(negedge clk);
`ifdef UART_PARITY_EN
        if (!badStop && !badParity) begin
`else
        if (!badStop) begin
`endif
            modelByte = b;
            modelFlag = 1'b1;
        end else begin
            modelErrCount++;
        end
    endtask

    task automatic clearFlag();
        @(negedge clk);
        uart_rx_clear = 1'b1;
        @(negedge clk);
        uart_rx_clear = 1'b0;
        modelFlag = 1'b0;
        checkOutput("clear_flag", {31'b0, uart_rx_flag}, 32'd0);
    endtask

    initial begin
        int lowCycles;
        logic [7:0] r1;
        logic [7:0] r2;
        rst = 1'b1;
        tx_data = '0;
        uart_tx_send = 1'b0;
        uart_rx_clear = 1'b0;
        rx_pin = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_pin", {31'b0, tx_pin}, 32'd1);
        checkOutput("reset_busy", {31'b0, uart_busy}, 32'd0);
        checkOutput("reset_rx_error", {31'b0, rx_error}, 32'd0);
        checkRxState("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] transmit 0xA5 with an ignored mid-frame send");
        applyTxStimulus(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) applyTxStimulus(8'($urandom_range(0, 255)), 1'b0);

        $display("[TB] receive 0x3C, then clear");
        applyRxStimulus(8'h3C, 1'b0, 1'b0, -1, lowCycles);
        checkRxState("rx_3c");
        clearFlag();

        $display("[TB] short low glitch on rx_pin");
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        rx_pin = 1'b1;
        repeat (30) @(negedge clk);
        checkRxState("glitch");
        r1 = 8'($urandom_range(0, 255));
        applyRxStimulus(r1, 1'b0, 1'b0, -1, lowCycles);
        checkRxState("after_glitch");
        clearFlag();

        $display("[TB] frame 0x55 with a bad stop bit");
        applyRxStimulus(8'h55, 1'b1, 1'b0, -1, lowCycles);
        checkRxState("bad_stop");

        $display("[TB] overrun with a clear on the completion edge");
        applyRxStimulus(8'h11, 1'b0, 1'b0, -1, lowCycles);
        checkRxState("rx_11");
        applyRxStimulus(8'h22, 1'b0, 1'b0, COMPLETE_N, lowCycles);
        checkRxState("rx_22_overrun");
        checkOutput("rx_22_flag_low_cycles", lowCycles, 0);

        $display("[TB] reset in the middle of a transmit frame");
        @(negedge clk);
        tx_data = 32'h0000_00F0;
        uart_tx_send = 1'b1;
        @(negedge clk);
        uart_tx_send = 1'b0;
        repeat (35) @(negedge clk);
        rst = 1'b0;
        #1;
        modelFlag = 1'b0;
        modelByte = 8'h00;
        checkOutput("midreset_tx_pin", {31'b0, tx_pin}, 32'd1);
        checkOutput("midreset_busy", {31'b0, uart_busy}, 32'd0);
        checkRxState("midreset");
        @(negedge clk);
        rst = 1'b1;
        applyTxStimulus(8'($urandom_range(0, 255)), 1'b0);
        applyTxStimulus(8'h07, 1'b0);
`ifdef UART_PARITY_EN
        $display("[TB] receive a frame with bad parity");
        applyRxStimulus(8'h5A, 1'b0, 1'b1, -1, lowCycles);
        checkRxState("bad_parity");
`endif

        $display("[TB] random receive frames");
        for (int i = 0; i < 3; i++) begin
            applyRxStimulus(8'($urandom_range(0, 255)), 1'b0, 1'b0, -1, lowCycles);
            checkRxState($sformatf("rx_rand%0d", i));
        end

        $display("[TB] simultaneous transmit and receive");
        r1 = 8'($urandom_range(0, 255));
        r2 = 8'($urandom_range(0, 255));
        fork
            applyTxStimulus(r1, 1'b0);
            applyRxStimulus(r2, 1'b0, 1'b0, -1, lowCycles);
        join
        checkRxState("concurrent");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
